// File: rtl/btn_debouncer.sv
// btn_debouncer
//   Conditions raw push-button pins for the button PIO peripheral. Each
//   channel runs through its own two-stage synchroniser, stability-counter
//   debouncer and edge detector. The debounced level is active-high.
//
// Parameters
//   N_BTN           number of independent button channels
//   DEBOUNCE_CYCLES consecutive identical synchronised samples needed to
//                   accept a new state (must be >= 2)
//   ACTIVE_LOW      1: the raw pin reads 0 while pressed; 0: reads 1 while pressed
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   btn_raw      asynchronous raw button pins
//   btn_level    debounced state, 1 = pressed (drives the PIO in_port)
//   btn_press    one-cycle pulse when a press is accepted
//   btn_release  one-cycle pulse when a release is accepted
module btn_debouncer #(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // Raw pin value of a released button; also used to normalise polarity.
  localparam logic [N_BTN-1:0] RAW_IDLE = (ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_WAIT_PRESS   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } state_t;

  logic [N_BTN-1:0] s1_q;
  logic [N_BTN-1:0] s2_q;
  logic [N_BTN-1:0] pressed;

  // Synchroniser resets to the released pin value so that leaving reset
  // never looks like a press edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= RAW_IDLE;
      s2_q <= RAW_IDLE;
    end else begin
      s1_q <= btn_raw;
      s2_q <= s1_q;
    end
  end

  assign pressed = s2_q ^ RAW_IDLE;

  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
      state_t           state_q;
      state_t           state_d;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             level_q;
      logic             level_d;
      logic             press_q;
      logic             press_d;
      logic             release_q;
      logic             release_d;
      logic             p;

      assign p = pressed[gi];

      // State register, counter and registered outputs.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          state_q   <= ST_RELEASED;
          cnt_q     <= '0;
          level_q   <= 1'b0;
          press_q   <= 1'b0;
          release_q <= 1'b0;
        end else begin
          state_q   <= state_d;
          cnt_q     <= cnt_d;
          level_q   <= level_d;
          press_q   <= press_d;
          release_q <= release_d;
        end
      end

      // Next state. cnt counts samples that disagree with the accepted
      // level; it tops out at CNT_LAST so it can never wrap.
      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
          ST_RELEASED: begin
            if (p) begin
              state_d = ST_WAIT_PRESS;
              cnt_d   = CNT_ONE;
            end else begin
              cnt_d   = '0;
            end
          end
          ST_WAIT_PRESS: begin
            if (!p) begin
              state_d = ST_RELEASED;
              cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
              state_d = ST_PRESSED;
              cnt_d   = '0;
            end else begin
              cnt_d   = cnt_q + CNT_ONE;
            end
          end
          ST_PRESSED: begin
            if (!p) begin
              state_d = ST_WAIT_RELEASE;
              cnt_d   = CNT_ONE;
            end else begin
              cnt_d   = '0;
            end
          end
          ST_WAIT_RELEASE: begin
            if (p) begin
              state_d = ST_PRESSED;
              cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
              state_d = ST_RELEASED;
              cnt_d   = '0;
            end else begin
              cnt_d   = cnt_q + CNT_ONE;
            end
          end
          default: begin
            state_d = ST_RELEASED;
            cnt_d   = '0;
          end
        endcase
      end

      // Outputs. Pulses fire only on the accepting transition, so they
      // are one cycle wide and press/release are mutually exclusive.
      always_comb begin
        press_d   = (state_q == ST_WAIT_PRESS)   &&  p && (cnt_q == CNT_LAST);
        release_d = (state_q == ST_WAIT_RELEASE) && !p && (cnt_q == CNT_LAST);
        level_d   = (state_d == ST_PRESSED) || (state_d == ST_WAIT_RELEASE);
      end

      assign btn_level[gi]   = level_q;
      assign btn_press[gi]   = press_q;
      assign btn_release[gi] = release_q;
    end
  endgenerate

endmodule

// File: tb/tb_btn_debouncer.sv
// tb_btn_debouncer
//   Self-checking bench for btn_debouncer (N_BTN = 2, DEBOUNCE_CYCLES = 4,
//   ACTIVE_LOW = 1). step() drives one cycle of raw input, advances a
//   run-length reference model and pushes the expected outputs for the
//   coming edge; each test pops and compares them after that edge.
module tb_btn_debouncer;

  localparam int DEB = 4;

  logic       clk;
  logic       reset_n;
  logic [1:0] btn_raw;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] btn_release;

  int checks = 0;
  int errors = 0;

  // Reference model: two-stage delay of the raw pins, then a count of
  // consecutive samples that disagree with the accepted level.
  logic [1:0] m_s1, m_s2, m_lvl, m_prs, m_rel;
  int         m_run [2];
  logic [5:0] sb [$];

  btn_debouncer #(
    .N_BTN          (2),
    .DEBOUNCE_CYCLES(DEB),
    .ACTIVE_LOW     (1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_s1  = 2'b11;
    m_s2  = 2'b11;
    m_lvl = 2'b00;
    m_prs = 2'b00;
    m_rel = 2'b00;
    m_run[0] = 0;
    m_run[1] = 0;
    sb.delete();
  endtask

  // Called at a falling edge: drive raw, model the next rising edge,
  // push the expected outputs, then wait for the next falling edge.
  task automatic step(input logic [1:0] raw);
    logic p;
    btn_raw = raw;
    m_prs = 2'b00;
    m_rel = 2'b00;
    for (int c = 0; c < 2; c++) begin
      p = ~m_s2[c];
      if (p != m_lvl[c]) m_run[c]++;
      else m_run[c] = 0;
      if (m_run[c] == DEB) begin
        m_lvl[c] = p;
        if (p) m_prs[c] = 1'b1;
        else   m_rel[c] = 1'b1;
        m_run[c] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = raw;
    sb.push_back({m_lvl, m_prs, m_rel});
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [5:0] exp;
    reset_n = 1'b0;
    btn_raw = 2'b11;
    repeat (3) @(negedge clk);
    checks++;
    if ({btn_level, btn_press, btn_release} !== 6'b0) begin
      errors++;
      $display("FAIL reset_values: got %b expected %b", {btn_level, btn_press, btn_release}, 6'b0);
    end
    model_reset();
    reset_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step(2'b11);
      exp = sb.pop_front();
      checks++;
      if ({btn_level, btn_press, btn_release} !== exp) begin
        errors++;
        $display("FAIL idle_edge%0d: got %b expected %b", k, {btn_level, btn_press, btn_release}, exp);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_clean_press();
    logic [5:0] exp;
    int edge_at = -1;
    for (int k = 1; k <= 10; k++) begin
      step(2'b10);
      exp = sb.pop_front();
      checks++;
      if ({btn_level, btn_press, btn_release} !== exp) begin
        errors++;
        $display("FAIL press_edge%0d: got %b expected %b", k, {btn_level, btn_press, btn_release}, exp);
      end
      if (btn_press[0] && edge_at < 0) edge_at = k;
    end
    checks++;
    if (edge_at !== DEB + 2) begin
      errors++;
      $display("FAIL press_latency: got %0d expected %0d", edge_at, DEB + 2);
    end
    $display("test_clean_press done, press at edge %0d", edge_at);
  endtask

  task automatic test_release();
    logic [5:0] exp;
    int edge_at = -1;
    for (int k = 1; k <= 10; k++) begin
      step(2'b11);
      exp = sb.pop_front();
      checks++;
      if ({btn_level, btn_press, btn_release} !== exp) begin
        errors++;
        $display("FAIL release_edge%0d: got %b expected %b", k, {btn_level, btn_press, btn_release}, exp);
      end
      if (btn_release[0] && edge_at < 0) edge_at = k;
    end
    checks++;
    if (edge_at !== DEB + 2) begin
      errors++;
      $display("FAIL release_latency: got %0d expected %0d", edge_at, DEB + 2);
    end
    $display("test_release done, release at edge %0d", edge_at);
  endtask

  task automatic test_bounce();
    logic [5:0] exp;
    int         dur [4] = '{2, 1, 3, 2};
    logic       val [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int         n_press = 0;
    int         edge_at = -1;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < dur[i]; k++) begin
        step({1'b1, val[i]});
        exp = sb.pop_front();
        checks++;
        if ({btn_level, btn_press, btn_release} !== exp) begin
          errors++;
          $display("FAIL bounce_seg%0d: got %b expected %b", i, {btn_level, btn_press, btn_release}, exp);
        end
        n_press += int'(btn_press[0]);
      end
    end
    for (int k = 1; k <= 10; k++) begin
      step(2'b10);
      exp = sb.pop_front();
      checks++;
      if ({btn_level, btn_press, btn_release} !== exp) begin
        errors++;
        $display("FAIL bounce_hold%0d: got %b expected %b", k, {btn_level, btn_press, btn_release}, exp);
      end
      n_press += int'(btn_press[0]);
      if (btn_press[0] && edge_at < 0) edge_at = k;
    end
    checks++;
    if (edge_at !== DEB + 2 || n_press !== 1) begin
      errors++;
      $display("FAIL bounce_pulse: got edge %0d count %0d expected edge %0d count 1", edge_at, n_press, DEB + 2);
    end
    for (int k = 1; k <= 10; k++) begin
      step(2'b11);
      exp = sb.pop_front();
      checks++;
      if ({btn_level, btn_press, btn_release} !== exp) begin
        errors++;
        $display("FAIL bounce_release%0d: got %b expected %b", k, {btn_level, btn_press, btn_release}, exp);
      end
    end
    $display("test_bounce done, press at edge %0d, %0d pulse(s)", edge_at, n_press);
  endtask

  task automatic test_simultaneous();
    logic [5:0] exp;
    int edge_at = -1;
    int n_single = 0;
    int n_change = 0;
    for (int k = 1; k <= 10; k++) begin
      step(2'b00);
      exp = sb.pop_front();
      checks++;
      if ({btn_level, btn_press, btn_release} !== exp) begin
        errors++;
        $display("FAIL both_edge%0d: got %b expected %b", k, {btn_level, btn_press, btn_release}, exp);
      end
      if (btn_press == 2'b11 && edge_at < 0) edge_at = k;
      if (btn_press == 2'b01 || btn_press == 2'b10) n_single++;
    end
    checks++;
    if (edge_at !== DEB + 2 || n_single !== 0) begin
      errors++;
      $display("FAIL both_press: got edge %0d single %0d expected edge %0d single 0", edge_at, n_single, DEB + 2);
    end
    for (int k = 1; k <= 11; k++) begin
      step((k <= 3) ? 2'b10 : 2'b00);
      exp = sb.pop_front();
      checks++;
      if ({btn_level, btn_press, btn_release} !== exp) begin
        errors++;
        $display("FAIL glitch_edge%0d: got %b expected %b", k, {btn_level, btn_press, btn_release}, exp);
      end
      if (btn_level !== 2'b11 || btn_press !== 2'b00 || btn_release !== 2'b00) n_change++;
    end
    checks++;
    if (n_change !== 0) begin
      errors++;
      $display("FAIL glitch_ignored: got %0d changed cycles expected 0", n_change);
    end
    for (int k = 1; k <= 10; k++) begin
      step(2'b11);
      exp = sb.pop_front();
      checks++;
      if ({btn_level, btn_press, btn_release} !== exp) begin
        errors++;
        $display("FAIL both_release%0d: got %b expected %b", k, {btn_level, btn_press, btn_release}, exp);
      end
    end
    $display("test_simultaneous done, joint press at edge %0d", edge_at);
  endtask

  task automatic test_reset_mid();
    logic [5:0] exp;
    int edge_at;
    int n_press;
    // Reset in the middle of WAIT_PRESS.
    for (int k = 1; k <= 5; k++) begin
      step(2'b10);
      exp = sb.pop_front();
      checks++;
      if ({btn_level, btn_press, btn_release} !== exp) begin
        errors++;
        $display("FAIL mid_wait%0d: got %b expected %b", k, {btn_level, btn_press, btn_release}, exp);
      end
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({btn_level, btn_press, btn_release} !== 6'b0) begin
      errors++;
      $display("FAIL reset_in_wait: got %b expected %b", {btn_level, btn_press, btn_release}, 6'b0);
    end
    @(negedge clk);
    model_reset();
    reset_n = 1'b1;
    edge_at = -1;
    for (int k = 1; k <= 8; k++) begin
      step(2'b10);
      exp = sb.pop_front();
      checks++;
      if ({btn_level, btn_press, btn_release} !== exp) begin
        errors++;
        $display("FAIL requal1_edge%0d: got %b expected %b", k, {btn_level, btn_press, btn_release}, exp);
      end
      if (btn_press[0] && edge_at < 0) edge_at = k;
    end
    checks++;
    if (edge_at !== DEB + 2) begin
      errors++;
      $display("FAIL requal1_latency: got %0d expected %0d", edge_at, DEB + 2);
    end
    // Reset while PRESSED: level must drop without waiting for a clock.
    reset_n = 1'b0;
    #1;
    checks++;
    if ({btn_level, btn_press, btn_release} !== 6'b0) begin
      errors++;
      $display("FAIL reset_in_pressed: got %b expected %b", {btn_level, btn_press, btn_release}, 6'b0);
    end
    @(negedge clk);
    model_reset();
    reset_n = 1'b1;
    edge_at = -1;
    n_press = 0;
    for (int k = 1; k <= 10; k++) begin
      step(2'b10);
      exp = sb.pop_front();
      checks++;
      if ({btn_level, btn_press, btn_release} !== exp) begin
        errors++;
        $display("FAIL requal2_edge%0d: got %b expected %b", k, {btn_level, btn_press, btn_release}, exp);
      end
      n_press += int'(btn_press[0]);
      if (btn_press[0] && edge_at < 0) edge_at = k;
    end
    checks++;
    if (edge_at !== DEB + 2 || n_press !== 1) begin
      errors++;
      $display("FAIL requal2_pulse: got edge %0d count %0d expected edge %0d count 1", edge_at, n_press, DEB + 2);
    end
    for (int k = 1; k <= 10; k++) begin
      step(2'b11);
      exp = sb.pop_front();
      checks++;
      if ({btn_level, btn_press, btn_release} !== exp) begin
        errors++;
        $display("FAIL final_release%0d: got %b expected %b", k, {btn_level, btn_press, btn_release}, exp);
      end
    end
    $display("test_reset_mid done, re-qualified press at edge %0d", edge_at);
  endtask

  initial begin
    reset_n = 1'b0;
    btn_raw = 2'b11;
    model_reset();
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
